// File: rtl/cfg_reg_center_pkg.sv
// Purpose: shared types and helpers for the configuration register centre.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package cfg_reg_center_pkg;

  // Control FSM of the register centre.
  typedef enum logic [2:0] {
    INIT,
    IDLE,
    MATCH,
    EXEC,
    RESP
  } state_t;

  // Default address of the W1C interrupt pending register.
  localparam logic [7:0] DEFAULT_INTR_ADDR = 8'hFF;

  // Upper bound on the slot count. The priority helper works at this width.
  localparam int MAX_NUM = 64;

  // Keeps only the lowest set bit of v. (~v + 1) is the two's complement of v.
  // ANDing it with v leaves only the least significant 1.
  function automatic logic [MAX_NUM-1:0] lowest_onehot(input logic [MAX_NUM-1:0] v);
    return v & (~v + 1'b1);
  endfunction

endpackage

// File: rtl/cfg_intr_collector.sv
// Purpose: per-slot trigger rising-edge detect, W1C pending register, irq.
// Latency: trigger edge -> pending in 2 edges; pending -> irq in 1 edge.
// Backpressure: none; a set and a clear of the same bit on one edge keep it set.
// Ports: clock, rst_n; en/trig per slot; clr_valid+clr_mask W1C clear;
//        pending per slot; irq = registered OR of pending.
module cfg_intr_collector #(
  parameter int NUM = 16
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic [NUM-1:0] en,
  input  logic [NUM-1:0] trig,
  input  logic           clr_valid,
  input  logic [NUM-1:0] clr_mask,
  output logic [NUM-1:0] pending,
  output logic           irq
);

  logic [NUM-1:0] trig_q;
  logic [NUM-1:0] trig_qq;
  logic [NUM-1:0] rise;
  logic [NUM-1:0] clr;

  // The edge is taken between two registered copies. Slots without an
  // interrupt source never report a rise.
  assign rise = en & trig_q & ~trig_qq;
  assign clr  = clr_valid ? clr_mask : '0;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      trig_q  <= '0;
      trig_qq <= '0;
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      trig_q  <= trig;
      trig_qq <= trig_q;
      // The set term is ORed in after the clear, so a new event is never lost.
      pending <= (pending & ~clr) | rise;
      irq     <= |pending;
    end
  end

endmodule

// File: rtl/cfg_reg_center.sv
// Purpose: host-facing register centre for NUM config slots, with address decode,
//          slot registers, default reload and interrupt aggregation.
// Latency: 3 cycles from accept to resp_valid; one request per 4 cycles.
// Backpressure: req_ready only in IDLE; resp_valid is a pulse with no stall.
// Ports: clock/rst_n; req_* host request; resp_* response pulse; slot_* packed
//        per-slot buses (slot i at [i*W +: W]); irq = any pending interrupt.
module cfg_reg_center
  import cfg_reg_center_pkg::*;
#(
  parameter int              NUM       = 16,
  parameter int              ASIZE     = 8,
  parameter int              DSIZE     = 32,
  parameter logic [ASIZE-1:0] INTR_ADDR = ASIZE'(DEFAULT_INTR_ADDR)
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ASIZE-1:0]     req_addr,
  input  logic [DSIZE-1:0]     req_wdata,
  output logic                 resp_valid,
  output logic [DSIZE-1:0]     resp_rdata,
  output logic                 resp_err,
  input  logic [NUM*ASIZE-1:0] slot_addr,
  output logic [NUM*DSIZE-1:0] slot_wdata,
  input  logic [NUM*DSIZE-1:0] slot_rdata,
  input  logic [NUM*DSIZE-1:0] slot_default,
  input  logic [NUM-1:0]       slot_rst,
  input  logic [NUM-1:0]       slot_intr_en,
  input  logic [NUM-1:0]       slot_intr_trig,
  output logic                 irq
);

  // The pending register must fit in one data word, and the priority helper
  // only spans MAX_NUM slots.
  if (NUM < 1 || NUM > MAX_NUM || NUM > DSIZE) begin : g_bad_num
    $error("cfg_reg_center: NUM must be 1..64 and not exceed DSIZE");
  end

  state_t             state;
  logic               wr_q;
  logic [ASIZE-1:0]   addr_q;
  logic [DSIZE-1:0]   wdata_q;
  logic [NUM-1:0]     hit_q;
  logic               intr_hit_q;
  logic               err_q;

  logic [NUM-1:0]     match_vec;
  logic [NUM-1:0]     hit_sel;
  logic [DSIZE-1:0]   rd_mux;
  logic [DSIZE-1:0]   pend_ext;
  logic [NUM-1:0]     pending;
  logic [NUM-1:0]     host_wr;
  logic               clr_valid;

  // Address decode against the latched request. The lowest matching slot wins.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < NUM; i++) begin
      match_vec[i] = (slot_addr[i*ASIZE +: ASIZE] == addr_q);
    end
    hit_sel = NUM'(lowest_onehot(MAX_NUM'(match_vec)));
  end

  // Readback mux. hit_q is one-hot or zero, so an OR reduction is enough.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM; i++) begin
      if (hit_q[i]) begin
        rd_mux = rd_mux | slot_rdata[i*DSIZE +: DSIZE];
      end
    end
    pend_ext = '0;
    pend_ext[NUM-1:0] = pending;
  end

  assign host_wr   = (state == EXEC && wr_q) ? hit_q : '0;
  assign clr_valid = (state == EXEC) && wr_q && intr_hit_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hit_q      <= '0;
      intr_hit_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        IDLE: begin
          if (req_valid) begin
            wr_q      <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            state     <= MATCH;
          end
        end
        MATCH: begin
          // The interrupt register shadows any slot mapped at the same address.
          intr_hit_q <= (addr_q == INTR_ADDR);
          hit_q      <= (addr_q == INTR_ADDR) ? '0 : hit_sel;
          err_q      <= (addr_q != INTR_ADDR) && !(|match_vec);
          state      <= EXEC;
        end
        EXEC: begin
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          if (err_q || wr_q) begin
            resp_rdata <= '0;
          end else if (intr_hit_q) begin
            resp_rdata <= pend_ext;
          end else begin
            resp_rdata <= rd_mux;
          end
          state <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Slot registers. A host write beats a same-edge reload. This lets a slot
  // whose reload is fed back from its own register produce a one-cycle pulse.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      slot_wdata <= '0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (host_wr[i]) begin
          slot_wdata[i*DSIZE +: DSIZE] <= wdata_q;
        end else if (state == INIT || slot_rst[i]) begin
          slot_wdata[i*DSIZE +: DSIZE] <= slot_default[i*DSIZE +: DSIZE];
        end
      end
    end
  end

  cfg_intr_collector #(
    .NUM (NUM)
  ) u_intr (
    .clock     (clock),
    .rst_n     (rst_n),
    .en        (slot_intr_en),
    .trig      (slot_intr_trig),
    .clr_valid (clr_valid),
    .clr_mask  (wdata_q[NUM-1:0]),
    .pending   (pending),
    .irq       (irq)
  );

endmodule

// File: tb/tb_cfg_reg_center.sv
module tb_cfg_reg_center;

  localparam int NUM   = 16;
  localparam int ASIZE = 8;
  localparam int DSIZE = 32;

  logic                 clock;
  logic                 rst_n;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ASIZE-1:0]     req_addr;
  logic [DSIZE-1:0]     req_wdata;
  logic                 resp_valid;
  logic [DSIZE-1:0]     resp_rdata;
  logic                 resp_err;
  logic [NUM*ASIZE-1:0] slot_addr;
  logic [NUM*DSIZE-1:0] slot_wdata;
  logic [NUM*DSIZE-1:0] slot_rdata;
  logic [NUM*DSIZE-1:0] slot_default;
  logic [NUM-1:0]       slot_rst;
  logic [NUM-1:0]       slot_rst_drv;
  logic [NUM-1:0]       slot_intr_en;
  logic [NUM-1:0]       slot_intr_trig;
  logic                 irq;

  int checks = 0;
  int errors = 0;
  int spurious = 0;
  bit mon_en = 0;

  // Slot 4 reloads whenever bit 0 of its own register is set.
  assign slot_rst = slot_rst_drv | {11'b0, slot_wdata[4*DSIZE], 4'b0};

  cfg_reg_center #(
    .NUM   (NUM),
    .ASIZE (ASIZE),
    .DSIZE (DSIZE)
  ) dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .slot_addr      (slot_addr),
    .slot_wdata     (slot_wdata),
    .slot_rdata     (slot_rdata),
    .slot_default   (slot_default),
    .slot_rst       (slot_rst),
    .slot_intr_en   (slot_intr_en),
    .slot_intr_trig (slot_intr_trig),
    .irq            (irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  always @(negedge clock) begin
    if (mon_en && resp_valid) spurious++;
  end

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          chk_slot;
    logic [31:0] exp_slot;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slot_w(input int i);
    return slot_wdata[i*DSIZE +: DSIZE];
  endfunction

  // Issues one request and returns at the cycle that carries resp_valid.
  task automatic do_req(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input bit raise6, output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 16) begin
      @(posedge clock); #1;
      n++;
    end
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (raise6) slot_intr_trig[6] = 1'b1;
    check("req_ready_busy", {31'b0, req_ready}, 32'd0);
    n = 0;
    while (resp_valid !== 1'b1 && n < 8) begin
      @(posedge clock); #1;
      n++;
    end
    check("resp_latency", 32'(n), 32'd2);
    rd = resp_rdata;
    er = resp_err;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
    end
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    slot_rst_drv   = '0;
    slot_intr_en   = '0;
    slot_intr_trig = '0;
    slot_rdata     = '0;
    slot_default   = '0;
    for (int i = 0; i < NUM; i++) slot_addr[i*ASIZE +: ASIZE] = 8'(8'h80 + i);
    slot_addr[2*8 +: 8] = 8'h10;
    slot_addr[1*8 +: 8] = 8'h20;
    slot_addr[5*8 +: 8] = 8'h20;
    slot_addr[4*8 +: 8] = 8'h30;
    slot_addr[7*8 +: 8] = 8'hFF;
    slot_default[3*32 +: 32] = 32'hA5;
    slot_default[5*32 +: 32] = 32'h55;
    slot_rdata[2*32 +: 32] = 32'hDEAD;
    slot_rdata[1*32 +: 32] = 32'h1111;
    slot_rdata[5*32 +: 32] = 32'h5555;
    slot_rdata[7*32 +: 32] = 32'hBAD;

    vecs[0] = '{1'b1, 8'h10, 32'h1234_5678, 32'h0,    1'b0, 2,  32'h1234_5678};
    vecs[1] = '{1'b0, 8'h10, 32'h0,         32'hDEAD, 1'b0, -1, 32'h0};
    vecs[2] = '{1'b0, 8'h77, 32'h0,         32'h0,    1'b1, -1, 32'h0};
    vecs[3] = '{1'b1, 8'h77, 32'h9999,      32'h0,    1'b1, -1, 32'h0};
    vecs[4] = '{1'b1, 8'h20, 32'hCAFE,      32'h0,    1'b0, 1,  32'hCAFE};
    vecs[5] = '{1'b0, 8'h20, 32'h0,         32'h1111, 1'b0, -1, 32'h0};
    vecs[6] = '{1'b0, 8'hFF, 32'h0,         32'h0,    1'b0, -1, 32'h0};

    // Reset and INIT
    cycles(2);
    check("rst_slot3", slot_w(3), 32'h0);
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("release_slot3", slot_w(3), 32'h0);
    cycles(2);
    check("init_slot3", slot_w(3), 32'hA5);
    check("init_ready", {31'b0, req_ready}, 32'd1);

    // Table-driven requests
    for (int v = 0; v < 7; v++) begin
      do_req(vecs[v].wr, vecs[v].addr, vecs[v].wdata, 1'b0, rd, er);
      check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
      check($sformatf("vec%0d_err", v), {31'b0, er}, {31'b0, vecs[v].exp_err});
      if (vecs[v].chk_slot >= 0)
        check($sformatf("vec%0d_slot", v), slot_w(vecs[v].chk_slot), vecs[v].exp_slot);
      cycles(1);
      check($sformatf("vec%0d_resp_drop", v), {31'b0, resp_valid}, 32'd0);
    end
    check("dup_slot5_untouched", slot_w(5), 32'h55);
    check("unmapped_write_slot2", slot_w(2), 32'h1234_5678);

    // Pulse reload
    do_req(1'b1, 8'h30, 32'h1, 1'b0, rd, er);
    check("pulse_high", slot_w(4), 32'h1);
    cycles(1);
    check("pulse_low", slot_w(4), 32'h0);

    // Interrupt set; slot 8 has no source enabled
    slot_intr_en[6] = 1'b1;
    cycles(2);
    slot_intr_trig[6] = 1'b1;
    slot_intr_trig[8] = 1'b1;
    cycles(4);
    check("irq_set", {31'b0, irq}, 32'd1);
    do_req(1'b0, 8'hFF, 32'h0, 1'b0, rd, er);
    check("pending_read", rd, 32'h40);

    // W1C clear
    do_req(1'b1, 8'hFF, 32'h40, 1'b0, rd, er);
    check("clr_err", {31'b0, er}, 32'd0);
    cycles(2);
    check("irq_cleared", {31'b0, irq}, 32'd0);

    // Rising edge coincident with the clear: the set wins
    slot_intr_trig[6] = 1'b0;
    cycles(3);
    do_req(1'b1, 8'hFF, 32'h40, 1'b1, rd, er);
    cycles(2);
    check("coincident_irq", {31'b0, irq}, 32'd1);
    do_req(1'b0, 8'hFF, 32'h0, 1'b0, rd, er);
    check("coincident_pending", rd, 32'h40);

    // Reset asserted during MATCH aborts the request
    slot_intr_trig[6] = 1'b0;
    cycles(3);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h10;
    req_wdata = 32'h9;
    @(posedge clock); #1;
    req_valid = 1'b0;
    mon_en = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_slot2", slot_w(2), 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'd0);
    check("midrst_ready", {31'b0, req_ready}, 32'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    check("midrst_init_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_init_slot3", slot_w(3), 32'hA5);
    check("midrst_slot2_after", slot_w(2), 32'h0);
    cycles(3);
    mon_en = 1'b0;
    check("midrst_no_resp", 32'(spurious), 32'd0);
    do_req(1'b0, 8'hFF, 32'h0, 1'b0, rd, er);
    check("midrst_pending", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_reg_center.md
# cfg_reg_center

Configuration centre that owns the register side of up to NUM `common_configure_reg_interface` slots. It takes single-beat read/write requests from a host bridge (AXI-Lite slave front end) and decodes the address against each slot's advertised `addr`. It holds each slot's `wdata` register, applies slot `default_value`/`rst` semantics, returns slot `rdata`, and aggregates slot interrupt triggers into one `irq`. It sits between the bus bridge and the per-module `CFG_REG`/`general_*` register instances.

## Interface
- NUM, 16, number of slots (1..64)
- ASIZE, 8, address width, matches the interface ASIZE
- DSIZE, 32, data width, matches the interface DSIZE
- INTR_ADDR, 8'hFF, address of the interrupt pending register (W1C)
- clock input 1 — single clock
- rst_n input 1 — asynchronous, active-low reset
- req_valid input 1 — host request valid
- req_ready output 1 — high only in IDLE
- req_write input 1 — 1 = write, 0 = read
- req_addr input ASIZE — request address
- req_wdata input DSIZE — write data
- resp_valid output 1 — one-cycle response pulse; no backpressure
- resp_rdata output DSIZE — read data (0 for writes and errors)
- resp_err output 1 — unmapped address
- slot_addr input NUM*ASIZE — per-slot address, slot i at [i*ASIZE +: ASIZE]
- slot_wdata output NUM*DSIZE — per-slot register value
- slot_rdata input NUM*DSIZE — per-slot readback
- slot_default input NUM*DSIZE — per-slot default value
- slot_rst input NUM — per-slot reload-to-default request
- slot_intr_en input NUM — slot has an interrupt source
- slot_intr_trig input NUM — slot interrupt level
- irq output 1 — OR of pending bits

## Operation
- **FSM states:** INIT, IDLE, MATCH, EXEC, RESP.
- **Reset and INIT:**
  - While rst_n is low: all slot_wdata=0, pending=0, irq=0, resp_*=0, req_ready=0, state=INIT.
  - INIT lasts one cycle. It loads slot_wdata[i]=slot_default[i] for every slot, then moves to IDLE.
- **IDLE:** req_ready=1. When req_valid is high, latch write/addr/wdata and go to MATCH.
- **MATCH:** register a one-hot hit vector from the addresses.
  - Hit: the lowest index i with slot_addr[i]==addr.
  - INTR_ADDR takes precedence over any slot with the same address.
  - No hit: err=1.
- **EXEC:**
  - Write hit: slot_wdata[i] <= wdata.
  - Write to INTR_ADDR: pending &= ~wdata[NUM-1:0].
  - Read hit: capture slot_rdata[i].
  - Read of INTR_ADDR: capture pending, zero-extended.
  - Error: no state change; capture data 0.
- **RESP:** resp_valid=1 for one cycle, then return to IDLE.
- **Slot reload:**
  - In any state, slot_rst[i] high reloads slot_wdata[i] from slot_default[i] at the next edge.
  - A host write to the same slot at that same edge wins over the reload, so the pulse register stays 1 for exactly one cycle.
- **Interrupts:**
  - Each slot with slot_intr_en[i] has its trigger registered.
  - A rising edge of the trigger sets pending[i].
  - When a set and a W1C clear of the same bit occur together, the set wins.
  - Slots without intr_en never set their pending bit.
  - irq is registered: irq = |pending, one cycle after pending changes.
- **Width rules:**
  - Address compare is exact over ASIZE bits.
  - The pending register width is NUM and is zero-extended to DSIZE.
  - NUM>DSIZE is illegal and must be rejected by an elaboration assertion.

## Timing
- Request accepted at edge 0 (req_valid & req_ready).
- MATCH occupies cycle 1 and EXEC cycle 2; the register update takes effect at the end of cycle 2.
- resp_valid is high in cycle 3. Fixed latency is 3 cycles from acceptance; throughput is one request per 4 cycles.
- req_ready is low from acceptance through RESP. A req_valid held high is not accepted again until the next IDLE.
- Read data is the slot_rdata value sampled in EXEC.
- Reset asserted mid-transaction aborts it; no resp_valid is issued.
- A trigger rising edge sets pending 2 cycles after the edge (1 for edge detect, 1 for the pending flop). irq follows 1 cycle after pending.

## Structure
- Package cfg_reg_center_pkg holds:
  - typedef enum for the FSM state (INIT, IDLE, MATCH, EXEC, RESP);
  - default INTR_ADDR constant;
  - function for lowest-index one-hot priority select.
- Sub-module cfg_intr_collector (NUM): trigger edge detect, pending register with W1C, irq.
  - Ports: clock, rst_n, en, trig, clr_valid, clr_mask, pending, irq.
- The top level holds the FSM, decode, and slot registers.

## Test plan
- **Reset/INIT:** slot_default[3]=32'hA5; release rst_n → slot_wdata[3]=0 during reset, 32'hA5 two edges after release; req_ready rises in IDLE.
- **Write/read:** slot_addr[2]=8'h10; write 32'h1234_5678 to 8'h10 → slot_wdata[2] updates on the EXEC edge, resp_valid 3 cycles after accept with err=0. Read 8'h10 with slot_rdata[2]=32'hDEAD → resp_rdata=32'hDEAD.
- **Unmapped and duplicate:** read 8'h77 with no slot mapped → resp_err=1, rdata=0. Slots 1 and 5 both at 8'h20; write → only slot 1 changes.
- **Pulse reload:** slot_rst[4] tied to slot_wdata[4][0], default 0; write 1 → slot_wdata[4]=1 for exactly one cycle, then 0.
- **Interrupt:**
  - slot_intr_en[6]=1, trigger 0→1 → pending[6] set, irq=1.
  - Read INTR_ADDR → 32'h40.
  - Write 32'h40 → irq clears.
  - Trigger edge coincident with the clear → bit stays set.
- **Mid-transaction reset:** assert rst_n low during MATCH → no resp_valid; slot_wdata and pending return to 0; after release, INIT then IDLE.
